m68040_bus_master: RTL

// - MC68040 local-bus initiator; the master side of the nTS/nTA protocol the chipset logic answers.
// - Arbitrates for the bus (nBR/nBG/nBB) and runs one single-beat read or write per request.
// - Sits between an internal requester (PCI bridge / DMA engine) and the CPU local bus.
// - Captures the result and reports the termination: normal, bus error or retry.

---
 rtl/m68040_bus_master_if.sv | 44 ++++
 rtl/m68040_bus_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/m68040_bus_master_if.sv
// Signal bundle between the MC68040 local-bus master, its internal requester and the CPU local bus.
// master = the bus-master block itself; slave = requester plus bus/chipset side.
interface m68040_bus_master_if #(
  parameter int ADDR_W = 32
);
  // requester side
  logic              REQ;
  logic              WR;
  logic [1:0]        SIZE;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       WDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [31:0]       RDATA;
  // 68040 local bus side
  logic              nBR;
  logic              nBG;
  logic              nBB_IN;
  logic              nBB_OUT;
  logic              BUS_OE;
  logic              D_OE;
  logic [ADDR_W-1:0] A_OUT;
  logic [31:0]       D_OUT;
  logic [31:0]       D_IN;
  logic              RnW;
  logic [1:0]        SIZ_OUT;
  logic [1:0]        TT_OUT;
  logic              nTS;
  logic              nTA;
  logic              nTEA;

  modport master (
    input  REQ, WR, SIZE, ADDR, WDATA, nBG, nBB_IN, D_IN, nTA, nTEA,
    output BUSY, DONE, ERR, RDATA, nBR, nBB_OUT, BUS_OE, D_OE,
           A_OUT, D_OUT, RnW, SIZ_OUT, TT_OUT, nTS
  );

  modport slave (
    output REQ, WR, SIZE, ADDR, WDATA, nBG, nBB_IN, D_IN, nTA, nTEA,
    input  BUSY, DONE, ERR, RDATA, nBR, nBB_OUT, BUS_OE, D_OE,
           A_OUT, D_OUT, RnW, SIZ_OUT, TT_OUT, nTS
  );
endinterface

// File: rtl/m68040_bus_master.sv
// MC68040 local-bus initiator: arbitrates via nBR/nBG/nBB, runs one single-beat transfer per REQ.
// Optional WAIT-state abort counter enabled by defining BUS_TIMEOUT_EN.
module m68040_bus_master #(
  parameter int ADDR_W      = 32,
  parameter int MAX_RETRY   = 3
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                 CLK40,
  input  logic                 nRESET,
  m68040_bus_master_if.master  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_TS   = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [2:0]        state_q, state_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              nbr_q, nbr_d;
  logic              nbb_q, nbb_d;
  logic              bus_oe_q, bus_oe_d;
  logic              d_oe_q, d_oe_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0]       dout_q, dout_d;
  logic              rnw_q, rnw_d;
  logic [1:0]        siz_q, siz_d;
  logic              nts_q, nts_d;
  logic [RW-1:0]     retry_q, retry_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]        tmo_q, tmo_d;
`endif

  logic term_ok, term_err, term_retry;
  assign term_ok    = ~bus.nTA &  bus.nTEA;
  assign term_err   =  bus.nTA & ~bus.nTEA;
  assign term_retry = ~bus.nTA & ~bus.nTEA;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    nbr_d    = nbr_q;
    nbb_d    = nbb_q;
    bus_oe_d = bus_oe_q;
    d_oe_d   = d_oe_q;
    a_d      = a_q;
    dout_d   = dout_q;
    rnw_d    = rnw_q;
    siz_d    = siz_q;
    nts_d    = 1'b1;
    retry_d  = retry_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          wr_d    = bus.WR;
          size_d  = bus.SIZE;
          addr_d  = bus.ADDR;
          wdata_d = bus.WDATA;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          nbr_d   = 1'b0;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        // Grant only counts once the previous master has let go of nBB.
        if (!bus.nBG && bus.nBB_IN) begin
          nbr_d    = 1'b1;
          bus_oe_d = 1'b1;
          nbb_d    = 1'b0;
          nts_d    = 1'b0;
          a_d      = addr_q;
          rnw_d    = ~wr_q;
          siz_d    = size_q;
          dout_d   = wdata_q;
          d_oe_d   = wr_q;
`ifdef BUS_TIMEOUT_EN
          tmo_d    = 8'd0;
`endif
          state_d  = S_TS;
        end
      end
      S_TS: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (term_ok) begin
          if (rnw_q) rdata_d = bus.D_IN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b0;
          nbb_d   = 1'b1;
          state_d = S_REL;
        end else if (term_err) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          nbb_d   = 1'b1;
          state_d = S_REL;
        end else if (term_retry) begin
          // Retry: release the bus entirely before re-arbitrating or giving up.
          bus_oe_d = 1'b0;
          d_oe_d   = 1'b0;
          nbb_d    = 1'b1;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            nbr_d   = 1'b0;
            state_d = S_ARB;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_REL;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          nbb_d   = 1'b1;
          state_d = S_REL;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_REL: begin
        bus_oe_d = 1'b0;
        d_oe_d   = 1'b0;
        retry_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      nbr_q    <= 1'b1;
      nbb_q    <= 1'b1;
      bus_oe_q <= 1'b0;
      d_oe_q   <= 1'b0;
      a_q      <= '0;
      dout_q   <= 32'd0;
      rnw_q    <= 1'b1;
      siz_q    <= 2'b00;
      nts_q    <= 1'b1;
      retry_q  <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      nbr_q    <= nbr_d;
      nbb_q    <= nbb_d;
      bus_oe_q <= bus_oe_d;
      d_oe_q   <= d_oe_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      rnw_q    <= rnw_d;
      siz_q    <= siz_d;
      nts_q    <= nts_d;
      retry_q  <= retry_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.RDATA   = rdata_q;
  assign bus.nBR     = nbr_q;
  assign bus.nBB_OUT = nbb_q;
  assign bus.BUS_OE  = bus_oe_q;
  assign bus.D_OE    = d_oe_q;
  assign bus.A_OUT   = a_q;
  assign bus.D_OUT   = dout_q;
  assign bus.RnW     = rnw_q;
  assign bus.SIZ_OUT = siz_q;
  assign bus.TT_OUT  = 2'b00;
  assign bus.nTS     = nts_q;

endmodule
